// File: rtl/s00_axi_regfile.sv
// AXI4-Lite slave holding four 32-bit control registers for the LED-cube display path.
// Exports live register contents plus a one-cycle commit pulse per register.
module s00_axi_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [31:0]                     reg0_out,
    output logic [31:0]                     reg1_out,
    output logic [31:0]                     reg2_out,
    output logic [31:0]                     reg3_out,
    output logic [3:0]                      reg_wr_pulse
);

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both 1; valid never waits on ready, and a source holds its
    // payload stable until the transfer edge.

    logic        rst_done;
    logic        aw_held;
    logic [1:0]  aw_idx;
    logic        w_held;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [31:0] regs [4];

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        commit;
    logic [1:0]  cm_idx;
    logic [31:0] cm_data;
    logic [3:0]  cm_strb;
    logic        unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    assign s00_axi_awready = rst_done & ~aw_held;
    assign s00_axi_wready  = rst_done & ~w_held;
    assign s00_axi_arready = rst_done & ~s00_axi_rvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_rresp   = 2'b00;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs = s00_axi_arvalid & s00_axi_arready;

    // A held half always takes priority; its channel is not ready, so no new beat can arrive.
    assign cm_idx  = aw_held ? aw_idx : s00_axi_awaddr[3:2];
    assign cm_data = w_held ? w_data : s00_axi_wdata;
    assign cm_strb = w_held ? w_strb : s00_axi_wstrb;
    assign commit  = (aw_held | aw_hs) & (w_held | w_hs) & (~s00_axi_bvalid | s00_axi_bready);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rst_done       <= 1'b0;
            aw_held        <= 1'b0;
            aw_idx         <= 2'd0;
            w_held         <= 1'b0;
            w_data         <= 32'd0;
            w_strb         <= 4'd0;
            s00_axi_bvalid <= 1'b0;
            reg_wr_pulse   <= 4'd0;
            for (int i = 0; i < 4; i++) regs[i] <= 32'd0;
        end else begin
            rst_done     <= 1'b1;
            reg_wr_pulse <= 4'd0;
            if (commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (cm_strb[b]) regs[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
                end
                reg_wr_pulse[cm_idx] <= 1'b1;
                s00_axi_bvalid       <= 1'b1;
                aw_held              <= 1'b0;
                w_held               <= 1'b0;
            end else begin
                if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_idx  <= s00_axi_awaddr[3:2];
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= s00_axi_wdata;
                    w_strb <= s00_axi_wstrb;
                end
            end
        end
    end

    // regs is sampled before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= 32'd0;
        end else if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= regs[s00_axi_araddr[3:2]];
        end else if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

    assign reg0_out = regs[0];
    assign reg1_out = regs[1];
    assign reg2_out = regs[2];
    assign reg3_out = regs[3];

endmodule

// File: tb/tb_s00_axi_regfile.sv
// Directed bench for s00_axi_regfile: vector table for plain writes/reads plus
// hand-written sequences for skew, backpressure, collision and mid-transaction reset.
module tb_s00_axi_regfile;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg0_out, reg1_out, reg2_out, reg3_out;
  logic [3:0]  reg_wr_pulse;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          rd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs[12];

  s00_axi_regfile dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg0_out        (reg0_out),
    .reg1_out        (reg1_out),
    .reg2_out        (reg2_out),
    .reg3_out        (reg3_out),
    .reg_wr_pulse    (reg_wr_pulse)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] reg_out(input logic [1:0] i);
    case (i)
      2'd0:    return reg0_out;
      2'd1:    return reg1_out;
      2'd2:    return reg2_out;
      default: return reg3_out;
    endcase
  endfunction

  function automatic logic [3:0] ready3();
    return {1'b0, awready, wready, arready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives AW and W together; returns #1 after the edge where both have been accepted.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic a, w, aw_done, w_done;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      @(negedge clk);
      a = awvalid & awready;
      w = wvalid & wready;
      tick();
      if (a) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_handshake", {30'd0, aw_done, w_done}, 32'd3);
  endtask

  task automatic axi_read(input logic [3:0] addr);
    logic a, done;
    araddr = addr; arvalid = 1'b1; done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      a = arvalid & arready;
      tick();
      if (a) begin done = 1'b1; arvalid = 1'b0; end
    end
    arvalid = 1'b0;
    check("read_handshake", {31'd0, done}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1'b0, 4'h0, 32'h0000_0001, 4'hF,    32'h0000_0001, 4'b0001};
    vecs[1]  = '{1'b0, 4'h4, 32'h0000_0002, 4'hF,    32'h0000_0002, 4'b0010};
    vecs[2]  = '{1'b0, 4'h8, 32'h0000_0003, 4'hF,    32'h0000_0003, 4'b0100};
    vecs[3]  = '{1'b0, 4'hC, 32'h0000_0004, 4'hF,    32'h0000_0004, 4'b1000};
    vecs[4]  = '{1'b1, 4'h0, 32'h0,         4'h0,    32'h0000_0001, 4'b0000};
    vecs[5]  = '{1'b1, 4'h4, 32'h0,         4'h0,    32'h0000_0002, 4'b0000};
    vecs[6]  = '{1'b1, 4'h8, 32'h0,         4'h0,    32'h0000_0003, 4'b0000};
    vecs[7]  = '{1'b1, 4'hC, 32'h0,         4'h0,    32'h0000_0004, 4'b0000};
    vecs[8]  = '{1'b0, 4'h4, 32'hFFFF_FFFF, 4'hF,    32'hFFFF_FFFF, 4'b0010};
    vecs[9]  = '{1'b0, 4'h5, 32'h1234_5678, 4'b0101, 32'hFF34_FF78, 4'b0010};
    vecs[10] = '{1'b0, 4'h6, 32'h0000_0000, 4'b0000, 32'hFF34_FF78, 4'b0010};
    vecs[11] = '{1'b1, 4'h7, 32'h0,         4'h0,    32'hFF34_FF78, 4'b0000};

    aresetn = 1'b0;
    awaddr = 4'd0; awprot = 3'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b1;
    araddr = 4'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b1;

    // Reset state
    #23;
    check("rst_readies", ready3(), 4'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_regs", reg0_out | reg1_out | reg2_out | reg3_out, 32'd0);
    check("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    check("rst_release_readies_low", ready3(), 4'd0);
    tick();
    check("rst_done_readies_high", ready3(), 4'b0111);

    // Table-driven writes and reads
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rd) begin
        axi_read(vecs[i].addr);
        check($sformatf("v%0d_rvalid", i), {31'd0, rvalid}, 32'd1);
        check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp);
        check($sformatf("v%0d_rresp", i), {30'd0, rresp}, 32'd0);
        tick();
        check($sformatf("v%0d_rvalid_clr", i), {31'd0, rvalid}, 32'd0);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check($sformatf("v%0d_bvalid", i), {31'd0, bvalid}, 32'd1);
        check($sformatf("v%0d_bresp", i), {30'd0, bresp}, 32'd0);
        check($sformatf("v%0d_pulse", i), {28'd0, reg_wr_pulse}, {28'd0, vecs[i].exp_pulse});
        check($sformatf("v%0d_reg", i), reg_out(vecs[i].addr[3:2]), vecs[i].exp);
        tick();
        check($sformatf("v%0d_bvalid_clr", i), {31'd0, bvalid}, 32'd0);
        check($sformatf("v%0d_pulse_clr", i), {28'd0, reg_wr_pulse}, 32'd0);
      end
    end

    // Channel skew: W three cycles ahead of AW
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("skew_wready_low", {31'd0, wready}, 32'd0);
    check("skew_awready_high", {31'd0, awready}, 32'd1);
    repeat (3) tick();
    check("skew_wait_wready", {31'd0, wready}, 32'd0);
    check("skew_wait_bvalid", {31'd0, bvalid}, 32'd0);
    check("skew_wait_reg2", reg2_out, 32'h0000_0003);
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("skew_reg2", reg2_out, 32'hDEAD_BEEF);
    check("skew_bvalid", {31'd0, bvalid}, 32'd1);
    check("skew_pulse", {28'd0, reg_wr_pulse}, 32'b0100);
    check("skew_wready_back", {31'd0, wready}, 32'd1);
    tick();

    // B backpressure: write A stalls its response, write B is held behind it
    bready = 1'b0;
    awaddr = 4'h0; wdata = 32'h0000_000A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_a_reg0", reg0_out, 32'h0000_000A);
    repeat (10) tick();
    check("bp_a_bvalid_held", {31'd0, bvalid}, 32'd1);
    awaddr = 4'h4; wdata = 32'h0000_00BB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_b_readies_low", ready3(), 4'b0001);
    check("bp_b_reg1_unchanged", reg1_out, 32'hFF34_FF78);
    repeat (2) tick();
    check("bp_b_still_held", reg1_out, 32'hFF34_FF78);
    check("bp_b_no_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    bready = 1'b1;
    tick();
    check("bp_b_reg1", reg1_out, 32'h0000_00BB);
    check("bp_b_bvalid_stays", {31'd0, bvalid}, 32'd1);
    check("bp_b_pulse", {28'd0, reg_wr_pulse}, 32'b0010);
    check("bp_b_readies_back", ready3(), 4'b0111);
    tick();
    check("bp_b_bvalid_clr", {31'd0, bvalid}, 32'd0);

    // R backpressure: rdata must hold while a competing AR waits
    rready = 1'b0;
    axi_read(4'h8);
    check("rbp_rdata", rdata, 32'hDEAD_BEEF);
    araddr = 4'h0; arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rbp_rdata_stable", rdata, 32'hDEAD_BEEF);
      check("rbp_arready_low", {31'd0, arready}, 32'd0);
      check("rbp_rvalid_held", {31'd0, rvalid}, 32'd1);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    check("rbp_rvalid_clr", {31'd0, rvalid}, 32'd0);

    // Same-edge read and write of reg3
    axi_write(4'hC, 32'h0000_0011, 4'hF);
    tick();
    araddr = 4'hC; arvalid = 1'b1;
    awaddr = 4'hC; wdata = 32'h0000_0022; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_rdata_old", rdata, 32'h0000_0011);
    check("coll_reg3_new", reg3_out, 32'h0000_0022);
    tick();
    axi_read(4'hC);
    check("coll_reread", rdata, 32'h0000_0022);
    tick();

    // Reset with a held AW and a stalled R
    rready = 1'b0;
    awaddr = 4'h0; awvalid = 1'b1;
    araddr = 4'h4; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check("mr_aw_held", {31'd0, awready}, 32'd0);
    check("mr_rvalid", {31'd0, rvalid}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mr_readies", ready3(), 4'd0);
    check("mr_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("mr_rdata", rdata, 32'd0);
    check("mr_regs", reg0_out | reg1_out | reg2_out | reg3_out, 32'd0);
    check("mr_pulse", {28'd0, reg_wr_pulse}, 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    rready = 1'b1;
    #1;
    check("mr_release_readies_low", ready3(), 4'd0);
    tick();
    check("mr_readies_high", ready3(), 4'b0111);
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (3) tick();
    check("mr_no_stale_commit", {31'd0, bvalid}, 32'd0);
    check("mr_reg0_zero", reg0_out, 32'd0);
    awaddr = 4'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("mr_new_reg1", reg1_out, 32'h0000_0055);
    check("mr_new_pulse", {28'd0, reg_wr_pulse}, 32'b0010);
    check("mr_reg0_still_zero", reg0_out, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
